// File: rtl/pkt_page_alloc.sv
// Packet-to-page allocator: streams packet words into linked-list pages taken
// from a prefetched free-page queue. It links pages as they fill and ends the
// chain at end of packet. A committed packet's start/end pages go to the
// forwarding stage. An aborted packet's chain goes back to the free list.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   crx_*                      packet word input stream (srdy/drdy, eop, commit, abort)
//   par_srdy / par_drdy        free-page request to the free list
//   parr_*                     free page returned by the free list
//   lnp_*                      link write (page -> next page or ENDPAGE)
//   pbra_*                     packet buffer write {page, line}, data
//   a2f_*                      committed packet (start page, end page)
//   ret_*                      aborted chain return (start page, end page)
module pkt_page_alloc #(
  parameter int unsigned    DW       = 64,
  parameter int unsigned    PGW      = 8,
  parameter int unsigned    LPP_LOG  = 2,
  parameter int unsigned    PREFETCH = 4,
  parameter logic [PGW-1:0] ENDPAGE  = {PGW{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   crx_srdy,
  output logic                   crx_drdy,
  input  logic [DW-1:0]          crx_data,
  input  logic                   crx_eop,
  input  logic                   crx_commit,
  input  logic                   crx_abort,
  output logic                   par_srdy,
  input  logic                   par_drdy,
  input  logic                   parr_srdy,
  output logic                   parr_drdy,
  input  logic [PGW-1:0]         parr_page,
  output logic                   lnp_srdy,
  input  logic                   lnp_drdy,
  output logic [PGW-1:0]         lnp_page,
  output logic [PGW-1:0]         lnp_next,
  output logic                   pbra_srdy,
  input  logic                   pbra_drdy,
  output logic [PGW+LPP_LOG-1:0] pbra_addr,
  output logic [DW-1:0]          pbra_data,
  output logic                   a2f_srdy,
  input  logic                   a2f_drdy,
  output logic [PGW-1:0]         a2f_start,
  output logic [PGW-1:0]         a2f_end,
  output logic                   ret_srdy,
  input  logic                   ret_drdy,
  output logic [PGW-1:0]         ret_start,
  output logic [PGW-1:0]         ret_end
);

  localparam int unsigned OW = $clog2(PREFETCH + 1);
  localparam int unsigned PW = $clog2(PREFETCH);
  localparam logic [OW-1:0]      PF_FULL   = OW'(PREFETCH);
  localparam logic [LPP_LOG-1:0] LAST_LINE = {LPP_LOG{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_LINK, S_TERM, S_COMMIT, S_ABORT
  } state_t;

  state_t state, state_d;

  // Prefetch queue of free pages plus the count of requests not yet consumed
  logic [PGW-1:0] pf_mem [PREFETCH];
  logic [PW-1:0]  pf_rd, pf_wr;
  logic [OW-1:0]  pf_cnt, pf_cnt_d;
  logic [OW-1:0]  outstanding, outstanding_d;
  logic           pf_push, pf_pop, pf_avail, grant;
  logic [PGW-1:0] pf_head;

  // Packet context
  logic [PGW-1:0]     cur, cur_d, start, start_d;
  logic [LPP_LOG-1:0] line, line_d;
  logic               cm, cm_d, ab, ab_d;
  logic               word_acc;

  // Next values of the registered handshake outputs
  logic           lnp_srdy_d, a2f_srdy_d, ret_srdy_d;
  logic [PGW-1:0] lnp_page_d, lnp_next_d, a2f_start_d, a2f_end_d;
  logic [PGW-1:0] ret_start_d, ret_end_d;

  assign pf_head  = pf_mem[pf_rd];
  assign pf_avail = (pf_cnt != '0);
  assign pf_push  = parr_srdy & parr_drdy;
  assign grant    = par_srdy & par_drdy;

  // Request and queue occupancy bookkeeping; grant+consume together cancel out
  always_comb begin
    outstanding_d = outstanding;
    pf_cnt_d      = pf_cnt;
    if (grant && !pf_pop)      outstanding_d = outstanding + OW'(1);
    else if (!grant && pf_pop) outstanding_d = outstanding - OW'(1);
    if (pf_push && !pf_pop)      pf_cnt_d = pf_cnt + OW'(1);
    else if (!pf_push && pf_pop) pf_cnt_d = pf_cnt - OW'(1);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state;
    cur_d       = cur;
    start_d     = start;
    line_d      = line;
    cm_d        = cm;
    ab_d        = ab;
    lnp_srdy_d  = lnp_srdy;
    lnp_page_d  = lnp_page;
    lnp_next_d  = lnp_next;
    a2f_srdy_d  = a2f_srdy;
    a2f_start_d = a2f_start;
    a2f_end_d   = a2f_end;
    ret_srdy_d  = ret_srdy;
    ret_start_d = ret_start;
    ret_end_d   = ret_end;
    pf_pop      = 1'b0;
    crx_drdy    = 1'b0;
    word_acc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (crx_srdy && pf_avail) begin
          pf_pop  = 1'b1;
          start_d = pf_head;
          cur_d   = pf_head;
          line_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Output stage accepts when empty or being drained this cycle
        crx_drdy = !pbra_srdy || pbra_drdy;
        word_acc = crx_srdy && crx_drdy;
        if (word_acc) begin
          line_d = line + LPP_LOG'(1);
          if (crx_eop) begin
            cm_d    = crx_commit;
            ab_d    = crx_abort;
            state_d = S_TERM;
          end else if (line == LAST_LINE) begin
            state_d = S_LINK;
          end
        end
      end
      S_LINK: begin
        // The queue head is only popped together with the link handshake
        if (!lnp_srdy) begin
          if (pf_avail) begin
            lnp_srdy_d = 1'b1;
            lnp_page_d = cur;
            lnp_next_d = pf_head;
          end
        end else if (lnp_drdy) begin
          lnp_srdy_d = 1'b0;
          pf_pop     = 1'b1;
          cur_d      = lnp_next;
          line_d     = '0;
          state_d    = S_WRITE;
        end
      end
      S_TERM: begin
        if (!lnp_srdy) begin
          lnp_srdy_d = 1'b1;
          lnp_page_d = cur;
          lnp_next_d = ENDPAGE;
        end else if (lnp_drdy) begin
          lnp_srdy_d = 1'b0;
          state_d    = (cm && !ab) ? S_COMMIT : S_ABORT;
        end
      end
      S_COMMIT: begin
        if (!a2f_srdy) begin
          a2f_srdy_d  = 1'b1;
          a2f_start_d = start;
          a2f_end_d   = cur;
        end else if (a2f_drdy) begin
          a2f_srdy_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!ret_srdy) begin
          ret_srdy_d  = 1'b1;
          ret_start_d = start;
          ret_end_d   = cur;
        end else if (ret_drdy) begin
          ret_srdy_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, context, prefetch and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      start       <= '0;
      line        <= '0;
      cm          <= 1'b0;
      ab          <= 1'b0;
      outstanding <= '0;
      pf_cnt      <= '0;
      pf_rd       <= '0;
      pf_wr       <= '0;
      par_srdy    <= 1'b0;
      parr_drdy   <= 1'b0;
      lnp_srdy    <= 1'b0;
      lnp_page    <= '0;
      lnp_next    <= '0;
      pbra_srdy   <= 1'b0;
      pbra_addr   <= '0;
      pbra_data   <= '0;
      a2f_srdy    <= 1'b0;
      a2f_start   <= '0;
      a2f_end     <= '0;
      ret_srdy    <= 1'b0;
      ret_start   <= '0;
      ret_end     <= '0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      start       <= start_d;
      line        <= line_d;
      cm          <= cm_d;
      ab          <= ab_d;
      outstanding <= outstanding_d;
      pf_cnt      <= pf_cnt_d;
      par_srdy    <= (outstanding_d < PF_FULL);
      parr_drdy   <= (pf_cnt_d < PF_FULL);
      if (pf_push) pf_wr <= pf_wr + PW'(1);
      if (pf_pop)  pf_rd <= pf_rd + PW'(1);
      lnp_srdy    <= lnp_srdy_d;
      lnp_page    <= lnp_page_d;
      lnp_next    <= lnp_next_d;
      a2f_srdy    <= a2f_srdy_d;
      a2f_start   <= a2f_start_d;
      a2f_end     <= a2f_end_d;
      ret_srdy    <= ret_srdy_d;
      ret_start   <= ret_start_d;
      ret_end     <= ret_end_d;
      // Single registered write stage
      if (word_acc) begin
        pbra_srdy <= 1'b1;
        pbra_addr <= {cur, line};
        pbra_data <= crx_data;
      end else if (pbra_drdy) begin
        pbra_srdy <= 1'b0;
      end
    end
  end

  // Free-page storage needs no reset; occupancy is tracked by pf_cnt
  always_ff @(posedge clk) begin
    if (pf_push) pf_mem[pf_wr] <= parr_page;
  end

endmodule

// File: tb/tb_pkt_page_alloc.sv
// Randomised bench for pkt_page_alloc. The bench acts as the free list, the
// packet source and every downstream sink. Expected writes, links and
// completions come from a page-list model: packet k takes the next
// ceil(len/4) pages in the order the free list handed them out.
module tb_pkt_page_alloc;

  logic        clk, reset;
  logic        crx_srdy, crx_drdy, crx_eop, crx_commit, crx_abort;
  logic [63:0] crx_data;
  logic        par_srdy, par_drdy, parr_srdy, parr_drdy;
  logic [7:0]  parr_page;
  logic        lnp_srdy, lnp_drdy;
  logic [7:0]  lnp_page, lnp_next;
  logic        pbra_srdy, pbra_drdy;
  logic [9:0]  pbra_addr;
  logic [63:0] pbra_data;
  logic        a2f_srdy, a2f_drdy, ret_srdy, ret_drdy;
  logic [7:0]  a2f_start, a2f_end, ret_start, ret_end;

  pkt_page_alloc dut (
    .clk(clk), .reset(reset),
    .crx_srdy(crx_srdy), .crx_drdy(crx_drdy), .crx_data(crx_data),
    .crx_eop(crx_eop), .crx_commit(crx_commit), .crx_abort(crx_abort),
    .par_srdy(par_srdy), .par_drdy(par_drdy),
    .parr_srdy(parr_srdy), .parr_drdy(parr_drdy), .parr_page(parr_page),
    .lnp_srdy(lnp_srdy), .lnp_drdy(lnp_drdy), .lnp_page(lnp_page), .lnp_next(lnp_next),
    .pbra_srdy(pbra_srdy), .pbra_drdy(pbra_drdy), .pbra_addr(pbra_addr), .pbra_data(pbra_data),
    .a2f_srdy(a2f_srdy), .a2f_drdy(a2f_drdy), .a2f_start(a2f_start), .a2f_end(a2f_end),
    .ret_srdy(ret_srdy), .ret_drdy(ret_drdy), .ret_start(ret_start), .ret_end(ret_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        eop, cm, ab;
  } word_t;

  word_t       tx_q[$];
  logic [9:0]  exp_pb_addr[$];
  logic [63:0] exp_pb_data[$];
  logic [15:0] exp_ln[$], exp_a2f[$], exp_ret[$];
  logic [7:0]  free_seq [1024];

  int n_chk = 0, n_pass = 0;
  int pend, ret_idx, mdl_idx;
  bit par_always, ret_en, stall, parr_fire;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Queue one packet and derive its expected writes, links and completion
  task automatic send_pkt(input int n, input bit cm, input bit ab);
    int npg = (n + 3) / 4;
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.d   = {$urandom, $urandom};
      w.eop = (i == n - 1);
      w.cm  = w.eop ? cm : 1'($urandom_range(0, 1));
      w.ab  = w.eop ? ab : 1'($urandom_range(0, 1));
      tx_q.push_back(w);
      exp_pb_addr.push_back(10'(free_seq[mdl_idx + i / 4] * 4 + i % 4));
      exp_pb_data.push_back(w.d);
    end
    for (int j = 0; j < npg; j++)
      exp_ln.push_back({free_seq[mdl_idx + j], (j == npg - 1) ? 8'hFF : free_seq[mdl_idx + j + 1]});
    if (cm && !ab) exp_a2f.push_back({free_seq[mdl_idx], free_seq[mdl_idx + npg - 1]});
    else           exp_ret.push_back({free_seq[mdl_idx], free_seq[mdl_idx + npg - 1]});
    mdl_idx += npg;
  endtask

  // One cycle: drive at negedge, then record handshakes firing at the next posedge
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    lnp_drdy  = ($urandom_range(0, 3) != 0);
    a2f_drdy  = ($urandom_range(0, 2) != 0);
    ret_drdy  = ($urandom_range(0, 2) != 0);
    pbra_drdy = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    par_drdy  = par_always ? 1'b1 : ($urandom_range(0, 1) != 0);
    if (!parr_srdy || parr_fire) begin
      parr_srdy = ret_en && (pend > 0) && ($urandom_range(0, 3) != 0);
      parr_page = free_seq[ret_idx];
    end
    if (tx_q.size() != 0 && (crx_srdy || $urandom_range(0, 3) != 0)) begin
      crx_srdy   = 1'b1;
      crx_data   = tx_q[0].d;
      crx_eop    = tx_q[0].eop;
      crx_commit = tx_q[0].cm;
      crx_abort  = tx_q[0].ab;
    end else begin
      crx_srdy = 1'b0;
      crx_eop  = 1'b0;
    end
    #1;
    parr_fire = parr_srdy && parr_drdy;
    if (parr_fire) begin ret_idx++; pend--; end
    if (par_srdy && par_drdy) pend++;
    if (crx_srdy && crx_drdy) void'(tx_q.pop_front());
    if (pbra_srdy && pbra_drdy) begin
      chk("pbra_expected", 64'(exp_pb_addr.size() != 0), 64'd1);
      if (exp_pb_addr.size() != 0) begin
        chk("pbra_addr", pbra_addr, exp_pb_addr.pop_front());
        chk("pbra_data", pbra_data, exp_pb_data.pop_front());
      end
    end
    if (lnp_srdy && lnp_drdy) begin
      chk("lnp_expected", 64'(exp_ln.size() != 0), 64'd1);
      if (exp_ln.size() != 0) begin
        e = exp_ln.pop_front();
        chk("lnp_page", lnp_page, e[15:8]);
        chk("lnp_next", lnp_next, e[7:0]);
      end
    end
    if (a2f_srdy && a2f_drdy) begin
      chk("a2f_expected", 64'(exp_a2f.size() != 0), 64'd1);
      if (exp_a2f.size() != 0) begin
        e = exp_a2f.pop_front();
        chk("a2f_start", a2f_start, e[15:8]);
        chk("a2f_end", a2f_end, e[7:0]);
      end
    end
    if (ret_srdy && ret_drdy) begin
      chk("ret_expected", 64'(exp_ret.size() != 0), 64'd1);
      if (exp_ret.size() != 0) begin
        e = exp_ret.pop_front();
        chk("ret_start", ret_start, e[15:8]);
        chk("ret_end", ret_end, e[7:0]);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || exp_pb_addr.size() != 0 || exp_ln.size() != 0 ||
            exp_a2f.size() != 0 || exp_ret.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_crx_drdy"}, crx_drdy, 0);
    chk({tag, "_par_srdy"}, par_srdy, 0);
    chk({tag, "_parr_drdy"}, parr_drdy, 0);
    chk({tag, "_lnp_srdy"}, lnp_srdy, 0);
    chk({tag, "_pbra_srdy"}, pbra_srdy, 0);
    chk({tag, "_a2f_srdy"}, a2f_srdy, 0);
    chk({tag, "_ret_srdy"}, ret_srdy, 0);
    chk({tag, "_pbra_addr"}, pbra_addr, 0);
    chk({tag, "_lnp_page"}, lnp_page, 0);
    chk({tag, "_lnp_next"}, lnp_next, 0);
    chk({tag, "_a2f_start"}, a2f_start, 0);
    chk({tag, "_ret_end"}, ret_end, 0);
  endtask

  // Forget every in-flight item; the DUT drops them on reset
  task automatic clear_model();
    tx_q.delete();
    exp_pb_addr.delete();
    exp_pb_data.delete();
    exp_ln.delete();
    exp_a2f.delete();
    exp_ret.delete();
    pend      = 0;
    parr_fire = 1'b0;
    parr_srdy = 1'b0;
    crx_srdy  = 1'b0;
    crx_eop   = 1'b0;
    stall     = 1'b0;
    mdl_idx   = ret_idx;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++)
      free_seq[i] = (i < 16) ? 8'(5 + i) : 8'($urandom_range(0, 254));
    reset = 1'b0;
    crx_srdy = 1'b0; crx_data = '0; crx_eop = 1'b0; crx_commit = 1'b0; crx_abort = 1'b0;
    par_drdy = 1'b0; parr_srdy = 1'b0; parr_page = '0;
    lnp_drdy = 1'b0; pbra_drdy = 1'b0; a2f_drdy = 1'b0; ret_drdy = 1'b0;
    pend = 0; ret_idx = 0; mdl_idx = 0;
    par_always = 1'b1; ret_en = 1'b0; stall = 1'b0; parr_fire = 1'b0;

    #2 reset = 1'b1;
    step();
    step();
    chk_reset_outputs("rst");
    @(negedge clk) reset = 1'b0;

    // With no pages returned, exactly PREFETCH requests may be granted
    for (int i = 0; i < 10; i++) step();
    chk("grants", 64'(pend), 64'd4);
    chk("par_srdy_full", par_srdy, 0);
    chk("parr_drdy_idle", parr_drdy, 1);

    ret_en     = 1'b1;
    par_always = 1'b0;
    send_pkt(3, 1'b1, 1'b0);
    drain("drain_3w", 2000);
    send_pkt(9, 1'b1, 1'b0);
    drain("drain_9w", 2000);
    send_pkt(4, 1'b1, 1'b0);
    drain("drain_4w", 2000);
    send_pkt(6, 1'b1, 1'b1);
    drain("drain_abort", 2000);
    send_pkt(1, 1'b1, 1'b0);
    send_pkt(1, 1'b0, 1'b0);
    drain("drain_single", 2000);

    for (int p = 0; p < 30; p++)
      send_pkt(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    drain("drain_random", 20000);

    // Stall the buffer write mid-packet, then reset while stalled
    send_pkt(12, 1'b1, 1'b0);
    n = 0;
    while (tx_q.size() > 9 && n < 500) begin step(); n++; end
    chk("pre_stall", 64'(n < 500), 64'd1);
    stall = 1'b1;
    n = 0;
    while (!pbra_srdy && n < 200) begin step(); n++; end
    chk("stall_fill", 64'(n < 200), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_crx_drdy", crx_drdy, 0);
      chk("stall_pbra_held", pbra_srdy, 1);
    end
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    clear_model();
    step();
    step();
    @(negedge clk) reset = 1'b0;

    send_pkt(5, 1'b1, 1'b0);
    drain("drain_after_reset", 2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
